multicycle_ctrl: RTL and testbench

Instruction-sequencing and decode stage that sits directly upstream of the register file, operand mux, sign extender and ALU.
- Accepts one 32-bit MIPS-subset instruction per transaction over a valid/ready handshake.
- Drives register addresses, the 16-bit immediate, the ALU operation code, the operand-select line and a write enable.
- Walks a 4-state FSM so the datapath has a full cycle to settle before writeback.
- Counts retired instructions.

---
 rtl/multicycle_pkg.sv | 45 ++++
 rtl/ctrl_decode.sv | 44 ++++
 rtl/multicycle_ctrl.sv | 93 +++++++++
 tb/tb_multicycle_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared opcode/funct/ALU encodings, FSM state type and decoder result struct.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multicycle_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation codes driven on 'control'
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    // Decoder result: ALU op, operand select (1 = register), legality,
    // and whether the destination register comes from the rt field.
    typedef struct packed {
        logic [3:0] control;
        logic       controll;
        logic       legal;
        logic       dest_is_rt;
    } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decoder producing ALU op, operand select, legality, dest select.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the inputs.
// Ports: opcode = instr[31:26], funct = instr[5:0]; dec = decoded control struct.
module ctrl_decode
    import multicycle_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec.control    = ALU_AND;
        dec.controll   = 1'b1;
        dec.legal      = 1'b0;
        dec.dest_is_rt = 1'b0;
        if (opcode == OP_RTYPE) begin
            dec.legal = 1'b1;
            case (funct)
                FN_AND:  dec.control = ALU_AND;
                FN_OR:   dec.control = ALU_OR;
                FN_ADD:  dec.control = ALU_ADD;
                FN_SUB:  dec.control = ALU_SUB;
                FN_SLT:  dec.control = ALU_SLT;
                FN_NOR:  dec.control = ALU_NOR;
                default: dec.legal   = 1'b0;
            endcase
        end else begin
            // I-type: second ALU operand is the extended immediate, write to rt
            dec.controll   = 1'b0;
            dec.dest_is_rt = 1'b1;
            dec.legal      = 1'b1;
            case (opcode)
                OP_ADDI: dec.control = ALU_ADD;
                OP_ANDI: dec.control = ALU_AND;
                OP_ORI:  dec.control = ALU_OR;
                OP_SLTI: dec.control = ALU_SLT;
                default: dec.legal   = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle decode/sequencing stage: IDLE -> DECODE -> EXEC -> WB, retired-instruction counter.
// Latency: decode outputs valid 1 cycle after transfer, reg_we in cycle 3, ready again in cycle 4.
// Backpressure: instr_ready only in IDLE (and never during reset); 1 instruction per 4 cycles max.
// Ports: clk/reset (sync, active-high); instr_valid/instr/instr_ready handshake;
//        inA/inB/inC register addresses, inD immediate, control ALU op, controll operand select,
//        reg_we write enable, illegal pulse, retired counter (CNT_W bits, wraps).
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic [4:0]       inA,
    output logic [4:0]       inB,
    output logic [4:0]       inC,
    output logic [15:0]      inD,
    output logic [3:0]       control,
    output logic             controll,
    output logic             reg_we,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t state, state_nxt;
    dec_t   dec;
    logic   take;

    assign instr_ready = (state == IDLE) && !reset;
    assign take        = instr_valid && instr_ready;

    ctrl_decode u_decode (
        .opcode (instr[31:26]),
        .funct  (instr[5:0]),
        .dec    (dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The registered 'illegal' flag is exactly "DECODE of an undecodable word",
    // so it doubles as the DECODE exit condition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = DECODE;
            DECODE:  state_nxt = illegal ? IDLE : EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inA      <= '0;
            inB      <= '0;
            inC      <= '0;
            inD      <= '0;
            control  <= '0;
            controll <= 1'b1;
            reg_we   <= 1'b0;
            illegal  <= 1'b0;
            retired  <= '0;
        end else begin
            illegal <= take && !dec.legal;
            // Registered so reg_we covers all of WB; r0 is never written.
            reg_we  <= (state == EXEC) && (inC != 5'd0);
            if (state == WB) begin
                retired <= retired + 1'b1;
            end
            // Decode fields are captured only at the handshake edge and then
            // held until the next transfer.
            if (take) begin
                inA      <= instr[25:21];
                inB      <= instr[20:16];
                inC      <= dec.dest_is_rt ? instr[20:16] : instr[15:11];
                inD      <= instr[15:0];
                control  <= dec.control;
                controll <= dec.controll;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam int TB_CNT_W = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                instr_valid;
    logic [31:0]         instr;
    logic                instr_ready;
    logic [4:0]          inA, inB, inC;
    logic [15:0]         inD;
    logic [3:0]          control;
    logic                controll;
    logic                reg_we;
    logic                illegal;
    logic [TB_CNT_W-1:0] retired;

    multicycle_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .inA         (inA),
        .inB         (inB),
        .inC         (inC),
        .inD         (inD),
        .control     (control),
        .controll    (controll),
        .reg_we      (reg_we),
        .illegal     (illegal),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // 'age' = cycles since the accepted instruction's transfer edge (0 = idle).
    int          age;
    logic        m_legal;
    logic        m_known;   // field expectations are defined
    logic        m_ill;
    int          m_ret;
    logic [4:0]  m_a, m_b, m_c;
    logic [15:0] m_d;
    int          m_alu;
    logic        m_sel;

    function automatic void ref_decode(input logic [31:0] w, output logic ok,
                                       output int alu, output logic sel,
                                       output logic [4:0] dst);
        logic [5:0] op;
        logic [5:0] fn;
        op  = w[31:26];
        fn  = w[5:0];
        ok  = 1'b1;
        alu = 0;
        if (op == 6'h00) begin
            sel = 1'b1;
            dst = w[15:11];
            case (fn)
                6'h24: alu = 0;
                6'h25: alu = 1;
                6'h20: alu = 2;
                6'h22: alu = 6;
                6'h2A: alu = 7;
                6'h27: alu = 12;
                default: ok = 1'b0;
            endcase
        end else begin
            sel = 1'b0;
            dst = w[20:16];
            case (op)
                6'h08: alu = 2;
                6'h0C: alu = 0;
                6'h0D: alu = 1;
                6'h0A: alu = 7;
                default: ok = 1'b0;
            endcase
        end
    endfunction

    task automatic model_update(input logic r, input logic v, input logic [31:0] w);
        logic       ok;
        int         alu;
        logic       sel;
        logic [4:0] dst;
        if (r) begin
            age = 0; m_ret = 0; m_ill = 1'b0; m_known = 1'b1;
            m_a = 0; m_b = 0; m_c = 0; m_d = 0; m_alu = 0; m_sel = 1'b1;
        end else begin
            m_ill = 1'b0;
            case (age)
                0: if (v) begin
                    ref_decode(w, ok, alu, sel, dst);
                    age     = 1;
                    m_legal = ok;
                    m_ill   = !ok;
                    m_known = ok;
                    if (ok) begin
                        m_a = w[25:21]; m_b = w[20:16]; m_c = dst;
                        m_d = w[15:0]; m_alu = alu; m_sel = sel;
                    end
                end
                1: age = m_legal ? 2 : 0;
                2: age = 3;
                default: begin
                    age   = 0;
                    m_ret = m_ret + 1;
                end
            endcase
        end
    endtask

    task automatic check_all(input logic r);
        chk("ready",   32'(instr_ready), 32'((age == 0) && !r));
        chk("reg_we",  32'(reg_we),      32'((age == 3) && (m_c != 5'd0)));
        chk("illegal", 32'(illegal),     32'(m_ill));
        chk("retired", 32'(retired),     32'(m_ret % (1 << TB_CNT_W)));
        if (m_known) begin
            chk("inA",      32'(inA),      32'(m_a));
            chk("inB",      32'(inB),      32'(m_b));
            chk("inC",      32'(inC),      32'(m_c));
            chk("inD",      32'(inD),      32'(m_d));
            chk("control",  32'(control),  32'(m_alu));
            chk("controll", 32'(controll), 32'(m_sel));
        end
    endtask

    // Drive inputs for one cycle, check outputs before the edge, advance model at the edge.
    task automatic step(input logic r, input logic v, input logic [31:0] w);
        reset = r; instr_valid = v; instr = w;
        #1;
        check_all(r);
        @(posedge clk);
        model_update(r, v, w);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input int idle_after);
        step(1'b0, 1'b1, w);
        for (int i = 0; i < idle_after; i++) step(1'b0, 1'b0, 32'h0);
    endtask

    logic [5:0] fn_tab [6] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h27};
    logic [5:0] op_tab [4] = '{6'h08, 6'h0C, 6'h0D, 6'h0A};

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          kind;
        w    = $urandom;
        kind = $urandom_range(0, 9);
        if (kind < 4) begin
            w[31:26] = 6'h00;
            w[5:0]   = fn_tab[$urandom_range(0, 5)];
        end else if (kind < 8) begin
            w[31:26] = op_tab[$urandom_range(0, 3)];
        end else if (kind == 8) begin
            w[31:26] = 6'h00;
        end
        if ($urandom_range(0, 7) == 0) w[15:11] = 5'd0;
        if ($urandom_range(0, 7) == 0) w[20:16] = 5'd0;
        return w;
    endfunction

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = 32'h0;
        age = 0; m_legal = 1'b0; m_known = 1'b0; m_ill = 1'b0; m_ret = 0;
        m_a = 0; m_b = 0; m_c = 0; m_d = 0; m_alu = 0; m_sel = 1'b1;
        #2;
        @(posedge clk);
        @(posedge clk);
        model_update(1'b1, 1'b0, 32'h0);
        #1;
        step(1'b1, 1'b0, 32'h0);               // reset state visible, ready forced low

        // Directed sequence
        send(32'h012A4020, 4);                 // add $8,$9,$10
        send(32'h312800FF, 4);                 // andi $8,$9,0xFF
        send(32'h0000003F, 2);                 // R-type, bad funct
        send(32'h012A0020, 4);                 // add $0,$9,$10 (r0 guard)
        send(32'h012A402A, 1);                 // slt, then reset during EXEC
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h012A4022);  // sub, valid held
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h012A4027);  // nor
        for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 32'h012A4020); // wrap retired

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7), rand_instr());
        end
        step(1'b0, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
